fetch_sequencer: RTL

- Multicycle instruction-fetch controller sequencing the program counter against an instruction memory with a req/ack handshake.
- Holds the current PC and fetches the word at it. Presents the instruction to decode with valid/ready, then advances PC by 4.
- Branch redirects from execute are accepted in any state. Any fetch still in flight is squashed.
- Sits between the PC datapath, the instruction memory port and the decode stage.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_sequencer.sv | 97 +++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic {
        REQ   = 1'b0,
        VALID = 1'b1
    } fetch_state_t;

    localparam int PC_INCR = 4;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer.sv
// Multicycle fetch controller: walks the PC through imem with req/ack,
// hands words to decode with valid/ready, and absorbs branch redirects.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR)
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              decode_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              squash_q, squash_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0] target;

    // Instructions are word aligned; ignore the low two target bits.
    assign target   = redirect_target & ~ADDR_W'(3);
    assign pc_plus4 = pc_q + ADDR_W'(PC_INCR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= REQ;
            pc_q     <= RESET_VECTOR;
            instr_q  <= '0;
            squash_q <= 1'b0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            squash_q <= squash_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        squash_d = squash_q;
        pend_d   = pend_q;
        unique case (state_q)
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d     = target;
                        squash_d = 1'b0;
                    end else if (squash_q) begin
                        pc_d     = pend_q;
                        squash_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = VALID;
                    end
                end else if (redirect) begin
                    // Address must hold until ack; park the target.
                    squash_d = 1'b1;
                    pend_d   = target;
                end
            end
            VALID: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (decode_ready) begin
                    pc_d    = pc_plus4;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_comb begin
        imem_req    = reset_n && (state_q == REQ);
        instr_valid = (state_q == VALID);
        imem_addr   = pc_q;
        pc          = pc_q;
        instr       = instr_q;
    end

endmodule
